// File: rtl/btn_pkg.sv
// Shared button-event definitions: FSM state encoding, default timing and a width helper.
// Also reused by the stopwatch top for its other button instances.
package btn_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPressed  = 2'd1,
        StLongHeld = 2'd2
    } btn_state_e;

    // 0.5 s long-press threshold and 0.1 s repeat period at 100 MHz.
    localparam int unsigned LongCyclesDefault   = 50000000;
    localparam int unsigned RepeatCyclesDefault = 10000000;
    localparam int unsigned CntWDefault         = 26;

    function automatic int unsigned cnt_w_min(input int unsigned long_c,
                                              input int unsigned repeat_c);
        int unsigned top;
        top = (long_c > repeat_c) ? long_c : repeat_c;
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/button_press_if.sv
// Debounced button level in, registered level and one-cycle press events out.
interface button_press_if;
    logic src;
    logic held;
    logic short_press;
    logic long_press;
    logic repeat_tick;

    modport master (
        output src,
        input  held,
        input  short_press,
        input  long_press,
        input  repeat_tick
    );

    modport slave (
        input  src,
        output held,
        output short_press,
        output long_press,
        output repeat_tick
    );
endinterface

// File: rtl/button_press.sv
// Turns a debounced button level into tap / long-press / auto-repeat pulses.
// Auto-repeat is built only when BUTTON_PRESS_AUTO_REPEAT_EN is defined.
module button_press
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LongCyclesDefault,
    parameter int unsigned REPEAT_CYCLES = RepeatCyclesDefault,
    parameter int unsigned CNT_W         = CntWDefault
) (
    input  logic           clk,
    input  logic           rst,
    button_press_if.slave  bus
);

    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("button_press: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("button_press: REPEAT_CYCLES must be >= 1");
    end
    if (CNT_W < cnt_w_min(LONG_CYCLES, REPEAT_CYCLES)) begin : g_bad_cnt_w
        $error("button_press: CNT_W too narrow for LONG_CYCLES/REPEAT_CYCLES");
    end

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
`ifdef BUTTON_PRESS_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RepeatLast    = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LongHeldStart = CntOne;
`else
    localparam logic [CNT_W-1:0] LongHeldStart = '0;
`endif

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             src_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rise;
    logic             at_long;

    // src_q resets high so a button held through reset never counts as a press.
    assign rise    = bus.src & ~src_q;
    assign at_long = (cnt_q == LongLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            src_q   <= 1'b1;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= bus.src;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPressed;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d = '0;
                end
            end
            StPressed: begin
                if (!bus.src) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (at_long) begin
                    state_d = StLongHeld;
                    cnt_d   = LongHeldStart;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StLongHeld: begin
                if (!bus.src) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
`ifdef BUTTON_PRESS_AUTO_REPEAT_EN
                else if (cnt_q == RepeatLast) begin
                    cnt_d = CntOne;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
`endif
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        short_d = (state_q == StPressed) && !bus.src;
        long_d  = (state_q == StPressed) && bus.src && at_long;
    end

`ifdef BUTTON_PRESS_AUTO_REPEAT_EN
    logic rep_q, rep_d;

    always_comb begin
        rep_d = (state_q == StLongHeld) && bus.src && (cnt_q == RepeatLast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign bus.repeat_tick = rep_q;
`else
    assign bus.repeat_tick = 1'b0;
`endif

    assign bus.held        = src_q;
    assign bus.short_press = short_q;
    assign bus.long_press  = long_q;

endmodule

// File: tb/tb_button_press.sv
// Directed bench for button_press with LONG_CYCLES=8, REPEAT_CYCLES=3.
// Follows BUTTON_PRESS_AUTO_REPEAT_EN for the expected repeat_tick pattern.
module tb_button_press;

    localparam int unsigned LongC   = 8;
    localparam int unsigned RepeatC = 3;
    localparam int unsigned CntW    = 4;

`ifdef BUTTON_PRESS_AUTO_REPEAT_EN
    localparam bit RepEn = 1'b1;
`else
    localparam bit RepEn = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    button_press_if bus ();

    button_press #(
        .LONG_CYCLES   (LongC),
        .REPEAT_CYCLES (RepeatC),
        .CNT_W         (CntW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Drive one edge, then compare {held, short, long, repeat} half a period later.
    task automatic cyc(input logic r, input logic s, input logic [2:0] exp_p, input string tag);
        logic [3:0] exp_v;
        logic [3:0] obs_v;
        rst     = r;
        bus.src = s;
        @(posedge clk);
        @(negedge clk);
        exp_v = {(r ? 1'b1 : s), exp_p};
        obs_v = {bus.held, bus.short_press, bus.long_press, bus.repeat_tick};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (held,short,long,repeat)", tag, obs_v, exp_v);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        bus.src = 1'b0;

        // Reset state: held=1 even with src low
        cyc(1'b1, 1'b0, 3'b000, "reset_src0");
        // Held through reset: no pulses until release and fresh press
        cyc(1'b1, 1'b1, 3'b000, "reset_src1");
        cyc(1'b0, 1'b1, 3'b000, "thru_reset_0");
        cyc(1'b0, 1'b1, 3'b000, "thru_reset_1");
        cyc(1'b0, 1'b1, 3'b000, "thru_reset_2");
        cyc(1'b0, 1'b0, 3'b000, "thru_release_0");
        cyc(1'b0, 1'b0, 3'b000, "thru_release_1");
        cyc(1'b0, 1'b1, 3'b000, "repress_e0");
        cyc(1'b0, 1'b1, 3'b000, "repress_e1");
        cyc(1'b0, 1'b0, 3'b100, "repress_short");
        cyc(1'b0, 1'b0, 3'b000, "repress_after");

        // Tap: src high E..E+2
        cyc(1'b0, 1'b1, 3'b000, "tap_e0");
        cyc(1'b0, 1'b1, 3'b000, "tap_e1");
        cyc(1'b0, 1'b1, 3'b000, "tap_e2");
        cyc(1'b0, 1'b0, 3'b100, "tap_short");
        cyc(1'b0, 1'b0, 3'b000, "tap_after");

        // Hold 20: long after E+8, repeats after E+11/14/17 when enabled
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b1,
                {1'b0, (k == 8), RepEn && (k == 11 || k == 14 || k == 17)},
                $sformatf("hold20_k%0d", k));
        end
        cyc(1'b0, 1'b0, 3'b000, "hold20_release");
        cyc(1'b0, 1'b0, 3'b000, "hold20_idle");

        // Threshold: release sampled at E+8 is still a short press
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 3'b000, $sformatf("thr_short_k%0d", k));
        end
        cyc(1'b0, 1'b0, 3'b100, "thr_short_e8");
        cyc(1'b0, 1'b0, 3'b000, "thr_short_after");
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 3'b000, $sformatf("thr_long_k%0d", k));
        end
        cyc(1'b0, 1'b1, 3'b010, "thr_long_e8");
        cyc(1'b0, 1'b0, 3'b000, "thr_long_release");
        cyc(1'b0, 1'b0, 3'b000, "thr_long_idle");

        // Reset mid-hold at E+10: nothing afterwards, not even the E+11 repeat
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, {1'b0, (k == 8), 1'b0}, $sformatf("midrst_k%0d", k));
        end
        cyc(1'b1, 1'b1, 3'b000, "midrst_e10");
        for (int k = 11; k < 15; k++) begin
            cyc(1'b0, 1'b1, 3'b000, $sformatf("midrst_k%0d", k));
        end
        cyc(1'b0, 1'b0, 3'b000, "midrst_release");
        cyc(1'b0, 1'b0, 3'b000, "midrst_idle");

        // Back-to-back single-cycle taps
        cyc(1'b0, 1'b1, 3'b000, "b2b_e0");
        cyc(1'b0, 1'b0, 3'b100, "b2b_short1");
        cyc(1'b0, 1'b1, 3'b000, "b2b_e2");
        cyc(1'b0, 1'b0, 3'b100, "b2b_short2");
        cyc(1'b0, 1'b0, 3'b000, "b2b_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
